// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, req/rvalid fetch handshake, IF/ID register with a one-entry skid buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_id,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [5:0]  id_opcode,
   output logic        fetch_fault
);

   // Handshake: a fetch completes in any cycle with imem_req && imem_rvalid; once
   // imem_req rises it stays high with imem_addr unchanged until that cycle.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_KILL  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] redir_pc, redir_pc_nx;
   logic [31:0] skid_instr, skid_instr_nx;
   logic [31:0] skid_pc, skid_pc_nx;
   logic        id_valid_nx;
   logic [31:0] id_instr_nx, id_pc_nx, id_pc_plus4_nx;
   logic [31:0] pc_next_seq;
   logic [31:0] target;
   logic        bad_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target       = redirect_pc;
   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

   logic fault_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            fault_q <= 1'b0;
      else if (bad_redirect) fault_q <= 1'b1;
   end
   assign fetch_fault = fault_q;
`else
   assign target       = redirect_pc & 32'hFFFF_FFFC;
   assign bad_redirect = 1'b0;
   assign fetch_fault  = 1'b0;
`endif

   assign pc_next_seq = pc + PC_STEP;
   assign imem_addr   = pc;
   assign id_opcode   = id_instr[31:26];

   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      redir_pc_nx    = redir_pc;
      skid_instr_nx  = skid_instr;
      skid_pc_nx     = skid_pc;
      id_valid_nx    = stall_id ? id_valid : 1'b0;
      id_instr_nx    = id_instr;
      id_pc_nx       = id_pc;
      id_pc_plus4_nx = id_pc_plus4;
      imem_req       = 1'b0;
      case (state)
         S_IDLE: begin
            state_nx = S_FETCH;
            if (redirect_valid) pc_nx = target;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (redirect_valid) begin
               if (imem_rvalid) begin
                  pc_nx = target;
               end else begin
                  redir_pc_nx = target;
                  state_nx    = S_KILL;
               end
            end else if (imem_rvalid) begin
               pc_nx = pc_next_seq;
               if (stall_id) begin
                  skid_instr_nx = imem_rdata;
                  skid_pc_nx    = pc;
                  state_nx      = S_HOLD;
               end else begin
                  id_valid_nx    = 1'b1;
                  id_instr_nx    = imem_rdata;
                  id_pc_nx       = pc;
                  id_pc_plus4_nx = pc_next_seq;
               end
            end
         end
         S_KILL: begin
            // Address must stay on the abandoned fetch until its response drains.
            imem_req = 1'b1;
            if (imem_rvalid) begin
               pc_nx    = redirect_valid ? target : redir_pc;
               state_nx = S_FETCH;
            end else if (redirect_valid) begin
               redir_pc_nx = target;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nx    = target;
               state_nx = S_FETCH;
            end else if (!stall_id) begin
               id_valid_nx    = 1'b1;
               id_instr_nx    = skid_instr;
               id_pc_nx       = skid_pc;
               id_pc_plus4_nx = skid_pc + PC_STEP;
               state_nx       = S_FETCH;
            end
         end
         S_FAULT: begin
            state_nx = S_FAULT;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      if (redirect_valid) id_valid_nx = 1'b0;
      // A trapped redirect leaves pc untouched and parks the stage for good.
      if (bad_redirect) begin
         state_nx    = S_FAULT;
         pc_nx       = pc;
         redir_pc_nx = redir_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         redir_pc    <= '0;
         skid_instr  <= '0;
         skid_pc     <= '0;
         id_valid    <= 1'b0;
         id_instr    <= '0;
         id_pc       <= '0;
         id_pc_plus4 <= '0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         redir_pc    <= redir_pc_nx;
         skid_instr  <= skid_instr_nx;
         skid_pc     <= skid_pc_nx;
         id_valid    <= id_valid_nx;
         id_instr    <= id_instr_nx;
         id_pc       <= id_pc_nx;
         id_pc_plus4 <= id_pc_plus4_nx;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap instance, randomized stream check, misaligned redirect.
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [5:0]  id_opcode;
   logic        fetch_fault;

   logic        w_rst_n;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic        w_id_valid;
   logic [31:0] w_id_instr;
   logic [31:0] w_id_pc;
   logic [31:0] w_id_pc_plus4;
   logic [5:0]  w_id_opcode;
   logic        w_fault;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h8C01_0004;
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_rdata = mem_word(imem_addr);
   assign w_rdata    = w_addr ^ 32'hA5A5_0000;

   fetch_stage u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4), .id_opcode(id_opcode), .fetch_fault(fetch_fault)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(1'b1), .imem_rdata(w_rdata),
      .stall_id(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc),
      .id_pc_plus4(w_id_pc_plus4), .id_opcode(w_id_opcode), .fetch_fault(w_fault)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic st, input logic rd, input logic [31:0] rpc);
      imem_rvalid    = rv;
      stall_id       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
   endtask

   typedef struct {
      logic        rv;
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        idv;
      logic [31:0] ipc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } vec_t;

   function automatic vec_t mk(input logic rv, input logic st, input logic rd, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr, input logic idv,
                               input logic [31:0] ipc, input logic [31:0] instr, input logic [31:0] pc4);
      vec_t v;
      v.rv = rv; v.st = st; v.rd = rd; v.rpc = rpc;
      v.req = req; v.addr = addr; v.idv = idv; v.ipc = ipc; v.instr = instr; v.pc4 = pc4;
      return v;
   endfunction

   vec_t vecs[14];

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m_next;
      logic        p_req, p_idv;
      logic [31:0] p_addr, p_pc, p_instr;
      logic [5:0]  exp_op;
      int          deliveries;
      bit          found;

      // sequential fetch, stall+skid, redirect during wait, redirect+stall+rvalid
      vecs[0]  = mk(0,0,0,32'h0,   1,32'h0,  0,32'h0,  32'h0,         32'h0);
      vecs[1]  = mk(1,0,0,32'h0,   1,32'h4,  1,32'h0,  32'hA5A5_0000, 32'h4);
      vecs[2]  = mk(1,0,0,32'h0,   1,32'h8,  1,32'h4,  32'hA5A5_0004, 32'h8);
      vecs[3]  = mk(1,1,0,32'h0,   0,32'hC,  1,32'h4,  32'hA5A5_0004, 32'h8);
      vecs[4]  = mk(1,1,0,32'h0,   0,32'hC,  1,32'h4,  32'hA5A5_0004, 32'h8);
      vecs[5]  = mk(0,0,0,32'h0,   1,32'hC,  1,32'h8,  32'h8C01_0004, 32'hC);
      vecs[6]  = mk(1,0,0,32'h0,   1,32'h10, 1,32'hC,  32'hA5A5_000C, 32'h10);
      vecs[7]  = mk(0,0,1,32'h100, 1,32'h10, 0,32'hC,  32'hA5A5_000C, 32'h10);
      vecs[8]  = mk(0,0,0,32'h0,   1,32'h10, 0,32'hC,  32'hA5A5_000C, 32'h10);
      vecs[9]  = mk(0,0,0,32'h0,   1,32'h10, 0,32'hC,  32'hA5A5_000C, 32'h10);
      vecs[10] = mk(1,0,0,32'h0,   1,32'h100,0,32'hC,  32'hA5A5_000C, 32'h10);
      vecs[11] = mk(1,0,0,32'h0,   1,32'h104,1,32'h100,32'hA5A5_0100, 32'h104);
      vecs[12] = mk(1,1,1,32'h40,  1,32'h40, 0,32'h100,32'hA5A5_0100, 32'h104);
      vecs[13] = mk(1,0,0,32'h0,   1,32'h44, 1,32'h40, 32'hA5A5_0040, 32'h44);

      // clock/reset
      rst_n   = 1'b0;
      w_rst_n = 1'b0;
      drive(0, 0, 0, 32'h0);
      #12;
      check1 ("rst_req",     imem_req,    1'b0);
      check32("rst_addr",    imem_addr,   32'h0);
      check1 ("rst_idv",     id_valid,    1'b0);
      check32("rst_instr",   id_instr,    32'h0);
      check32("rst_pc",      id_pc,       32'h0);
      check32("rst_pc4",     id_pc_plus4, 32'h0);
      check1 ("rst_fault",   fetch_fault, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check1("idle_req", imem_req, 1'b0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rv, vecs[i].st, vecs[i].rd, vecs[i].rpc);
         @(posedge clk);
         #1;
         exp_op = vecs[i].instr[31:26];
         check1 ($sformatf("vec%0d_req",   i), imem_req,    vecs[i].req);
         check32($sformatf("vec%0d_addr",  i), imem_addr,   vecs[i].addr);
         check1 ($sformatf("vec%0d_idv",   i), id_valid,    vecs[i].idv);
         check32($sformatf("vec%0d_pc",    i), id_pc,       vecs[i].ipc);
         check32($sformatf("vec%0d_instr", i), id_instr,    vecs[i].instr);
         check32($sformatf("vec%0d_pc4",   i), id_pc_plus4, vecs[i].pc4);
         check32($sformatf("vec%0d_op",    i), {26'd0, id_opcode}, {26'd0, exp_op});
      end

      // wrap-around instance
      @(negedge clk);
      w_rst_n = 1'b1;
      @(posedge clk); #1;
      check1 ("wrap_req0",  w_req,  1'b1);
      check32("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      check32("wrap_addr1", w_addr,        32'h0);
      check1 ("wrap_idv",   w_id_valid,    1'b1);
      check32("wrap_pc",    w_id_pc,       32'hFFFF_FFFC);
      check32("wrap_pc4",   w_id_pc_plus4, 32'h0);
      @(posedge clk); #1;
      check32("wrap_instr", w_id_instr,    32'hA5A5_0000);
      check1 ("wrap_fault", w_fault,       1'b0);

      // async reset mid-stream, then random stream against delivered-pc model
      #3;
      rst_n = 1'b0;
      #1;
      check1("async_rst_req", imem_req, 1'b0);
      check1("async_rst_idv", id_valid, 1'b0);
      drive(0, 0, 0, 32'h0);
      @(negedge clk);
      rst_n      = 1'b1;
      m_next     = 32'h0;
      deliveries = 0;
      for (int c = 0; c < 2000; c++) begin
         drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 6), 32'h1000 + ($urandom_range(0, 63) << 2));
         p_req = imem_req; p_addr = imem_addr; p_idv = id_valid; p_pc = id_pc; p_instr = id_instr;
         @(posedge clk);
         #1;
         if (redirect_valid) begin
            check1("rnd_flush", id_valid, 1'b0);
            m_next = redirect_pc;
         end else if (stall_id) begin
            check1 ("rnd_hold_v",  id_valid, p_idv);
            check32("rnd_hold_pc", id_pc,    p_pc);
            check32("rnd_hold_in", id_instr, p_instr);
         end else if (id_valid) begin
            exp_op = mem_word(m_next) >> 26;
            check32("rnd_pc",    id_pc,       m_next);
            check32("rnd_instr", id_instr,    mem_word(m_next));
            check32("rnd_pc4",   id_pc_plus4, m_next + 32'd4);
            check32("rnd_op",    {26'd0, id_opcode}, {26'd0, exp_op});
            m_next = m_next + 32'd4;
            deliveries++;
         end
         if (p_req && !imem_rvalid) begin
            check1 ("rnd_req_stable",  imem_req,  1'b1);
            check32("rnd_addr_stable", imem_addr, p_addr);
         end
      end
      check1("rnd_progress", deliveries > 100, 1'b1);

      // misaligned redirect
      drive(0, 0, 1, 32'h0000_0102);
      @(posedge clk); #1;
      check1("mis_idv", id_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check1("mis_fault", fetch_fault, 1'b1);
      check1("mis_req",   imem_req,    1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, (k == 1), 32'h200);
         @(posedge clk); #1;
         check1($sformatf("mis_req_off%0d", k),  imem_req,    1'b0);
         check1($sformatf("mis_fault_k%0d", k), fetch_fault, 1'b1);
      end
`else
      check1("mis_fault", fetch_fault, 1'b0);
      found = imem_req && (imem_addr == 32'h100);
      for (int k = 0; k < 8 && !found; k++) begin
         drive(1, 0, 0, 32'h0);
         @(posedge clk); #1;
         found = imem_req && (imem_addr == 32'h100);
      end
      check1("mis_addr_0x100", found, 1'b1);
      drive(1, 0, 0, 32'h0);
      @(posedge clk); #1;
      check32("mis_deliver_pc", id_pc,       32'h100);
      check1 ("mis_fault_end",  fetch_fault, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
